// File: rtl/summator_pkg.sv
// Shared definitions for the windowed accumulator: FSM state encoding and default widths.
package summator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W   = 10;
    localparam int unsigned DEF_SUM_W    = 19;
    localparam int unsigned DEF_CH       = 1;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_SIGNED   = 0;
    localparam int unsigned DEF_SATURATE = 1;

endpackage

// File: rtl/accum_lane.sv
// One accumulator channel: extend, add, overflow detect, saturate or wrap, sticky overflow.
module accum_lane #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned SUM_W    = 19,
    parameter int unsigned SIGNED   = 0,
    parameter int unsigned SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] a_i,
    output logic [SUM_W-1:0]  y_o,
    output logic              ovf_o
);

    localparam int unsigned EXT = SUM_W - DATA_W + 1;

    logic [SUM_W-1:0] acc_q, acc_d, y_q, y_d, base, smax, smin, sat, res;
    logic [SUM_W:0]   a_ext, base_ext, sum;
    logic             wovf_q, wovf_d, ovf_q, ovf_d, ov, wovf_acc;

    always_comb begin
        smax = {1'b0, {(SUM_W-1){1'b1}}};
        smin = {1'b1, {(SUM_W-1){1'b0}}};
        // A sample coinciding with the window restart adds onto zero, not the stale sum.
        base     = clr_i ? '0 : acc_q;
        a_ext    = (SIGNED != 0) ? {{EXT{a_i[DATA_W-1]}}, a_i} : {{EXT{1'b0}}, a_i};
        base_ext = (SIGNED != 0) ? {base[SUM_W-1], base} : {1'b0, base};
        sum      = base_ext + a_ext;
        ov       = (SIGNED != 0) ? (sum[SUM_W] ^ sum[SUM_W-1]) : sum[SUM_W];
        sat      = (SIGNED != 0) ? (sum[SUM_W] ? smin : smax) : '1;
        res      = (ov && (SATURATE != 0)) ? sat : sum[SUM_W-1:0];
        wovf_acc = (clr_i ? 1'b0 : wovf_q) | ov;

        acc_d  = acc_q;
        wovf_d = wovf_q;
        y_d    = y_q;
        ovf_d  = ovf_q;
        if (add_i) begin
            if (last_i) begin
                y_d    = res;
                ovf_d  = wovf_acc;
                acc_d  = '0;
                wovf_d = 1'b0;
            end else begin
                acc_d  = res;
                wovf_d = wovf_acc;
            end
        end else if (clr_i) begin
            acc_d  = '0;
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            wovf_q <= 1'b0;
            y_q    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wovf_q <= wovf_d;
            y_q    <= y_d;
            ovf_q  <= ovf_d;
        end
    end

    assign y_o   = y_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/accum_window.sv
// Multi-channel windowed accumulator: shared window FSM/counter driving CH independent lanes.
module accum_window
    import summator_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned SUM_W    = DEF_SUM_W,
    parameter int unsigned CH       = DEF_CH,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned SIGNED   = DEF_SIGNED,
    parameter int unsigned SATURATE = DEF_SATURATE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                sof,
    input  logic [CNT_W-1:0]    len,
    input  logic [CH*DATA_W-1:0] A,
    output logic [CH*SUM_W-1:0] Y,
    output logic                valid,
    output logic                busy,
    output logic [CH-1:0]       ovf
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, eff_cnt, eff_len;
    logic             valid_q, take, last;

    // An accepted sof is treated as a fresh window of the new length, so a coinciding
    // sample (and a len=1 completion) goes through the same counting path.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        eff_cnt = cnt_q;
        eff_len = len_q;
        take    = 1'b0;
        if (sof) begin
            eff_cnt = '0;
            eff_len = len;
            if (len == '0) begin
                state_d = IDLE;
            end else begin
                state_d = ACC;
                len_d   = len;
                take    = ce;
            end
        end else begin
            take = (state_q == ACC) && ce;
        end
        last  = take && (eff_cnt == eff_len - CNT_W'(1));
        cnt_d = take ? (last ? '0 : eff_cnt + CNT_W'(1)) : eff_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            valid_q <= last;
        end
    end

    assign valid = valid_q;
    assign busy  = (state_q == ACC);

    for (genvar k = 0; k < CH; k++) begin : g_lane
        accum_lane #(
            .DATA_W  (DATA_W),
            .SUM_W   (SUM_W),
            .SIGNED  (SIGNED),
            .SATURATE(SATURATE)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr_i (sof),
            .add_i (take),
            .last_i(last),
            .a_i   (A[k*DATA_W +: DATA_W]),
            .y_o   (Y[k*SUM_W +: SUM_W]),
            .ovf_o (ovf[k])
        );
    end

endmodule

// File: tb/tb_accum_window.sv
// Directed bench for accum_window: table-driven default config plus signed, wrap and multi-channel sequences.
module tb_accum_window;

    logic        clk = 1'b0;
    logic        rst, ce, sof;
    logic [15:0] len;
    logic [9:0]  a0, a1, a2;
    logic [23:0] a3;
    logic [18:0] y0;
    logic [11:0] y1;
    logic [10:0] y2;
    logic [29:0] y3;
    logic        v0, v1, v2, v3, b0, b1, b2, b3;
    logic        o0, o1, o2;
    logic [2:0]  o3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    accum_window u0 (
        .clk(clk), .rst(rst), .ce(ce), .sof(sof), .len(len), .A(a0),
        .Y(y0), .valid(v0), .busy(b0), .ovf(o0));

    accum_window #(.SUM_W(12), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .sof(sof), .len(len), .A(a1),
        .Y(y1), .valid(v1), .busy(b1), .ovf(o1));

    accum_window #(.SUM_W(11), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .ce(ce), .sof(sof), .len(len), .A(a2),
        .Y(y2), .valid(v2), .busy(b2), .ovf(o2));

    accum_window #(.DATA_W(8), .SUM_W(10), .CH(3)) u3 (
        .clk(clk), .rst(rst), .ce(ce), .sof(sof), .len(len), .A(a3),
        .Y(y3), .valid(v3), .busy(b3), .ovf(o3));

    typedef struct {
        logic        s;
        logic        c;
        logic [15:0] l;
        logic [9:0]  a;
        logic        v;
        logic        b;
        logic [18:0] y;
        logic        o;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic c, input logic [15:0] l,
                                input logic [9:0] a, input logic v, input logic b,
                                input logic [18:0] y, input logic o);
        vec_t r;
        r.s = s; r.c = c; r.l = l; r.a = a; r.v = v; r.b = b; r.y = y; r.o = o;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic c, input logic [15:0] l);
        sof = s;
        ce  = c;
        len = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; sof = 1'b0; len = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.y0", y0, 0);
        chk("reset.valid0", v0, 0);
        chk("reset.busy0", b0, 0);
        chk("reset.ovf0", o0, 0);
        chk("reset.y3", y3, 0);
        rst = 1'b0;

        //            sof ce len  a   | v  busy y    ovf
        tbl.push_back(mk(1, 1, 4, 10,   0, 1, 0,   0));
        tbl.push_back(mk(0, 1, 4, 20,   0, 1, 0,   0));
        tbl.push_back(mk(0, 0, 4, 99,   0, 1, 0,   0));
        tbl.push_back(mk(0, 1, 4, 30,   0, 1, 0,   0));
        tbl.push_back(mk(0, 1, 4, 40,   1, 1, 100, 0));
        tbl.push_back(mk(0, 1, 4, 1,    0, 1, 100, 0));
        tbl.push_back(mk(0, 1, 4, 1,    0, 1, 100, 0));
        tbl.push_back(mk(0, 1, 4, 1,    0, 1, 100, 0));
        tbl.push_back(mk(0, 1, 4, 1,    1, 1, 4,   0));
        tbl.push_back(mk(1, 1, 4, 7,    0, 1, 4,   0));
        tbl.push_back(mk(0, 1, 4, 7,    0, 1, 4,   0));
        tbl.push_back(mk(1, 1, 4, 5,    0, 1, 4,   0));
        tbl.push_back(mk(0, 1, 4, 5,    0, 1, 4,   0));
        tbl.push_back(mk(0, 1, 4, 5,    0, 1, 4,   0));
        tbl.push_back(mk(0, 1, 4, 5,    1, 1, 20,  0));
        tbl.push_back(mk(1, 1, 0, 3,    0, 0, 20,  0));
        tbl.push_back(mk(0, 1, 0, 3,    0, 0, 20,  0));
        tbl.push_back(mk(1, 1, 1, 9,    1, 1, 9,   0));
        tbl.push_back(mk(0, 1, 1, 8,    1, 1, 8,   0));
        tbl.push_back(mk(0, 0, 1, 8,    0, 1, 8,   0));

        for (int i = 0; i < tbl.size(); i++) begin
            a0 = tbl[i].a;
            step(tbl[i].s, tbl[i].c, tbl[i].l);
            chk($sformatf("vec%0d.valid", i), v0, tbl[i].v);
            chk($sformatf("vec%0d.busy", i), b0, tbl[i].b);
            chk($sformatf("vec%0d.y", i), y0, tbl[i].y);
            chk($sformatf("vec%0d.ovf", i), o0, tbl[i].o);
        end

        // Signed in-range window and unsigned wrap window, side by side.
        a1 = 10'h200;
        a2 = 10'd1000;
        step(1, 1, 3);
        step(0, 1, 3);
        chk("signed3.novalid", v1, 0);
        step(0, 1, 3);
        chk("signed3.valid", v1, 1);
        chk("signed3.y", y1, 12'hA00);
        chk("signed3.ovf", o1, 0);
        chk("wrap3.valid", v2, 1);
        chk("wrap3.y", y2, 11'd952);
        chk("wrap3.ovf", o2, 1);

        step(1, 1, 5);
        chk("signed5.hold", y1, 12'hA00);
        for (int i = 0; i < 4; i++) step(0, 1, 5);
        chk("signed5.valid", v1, 1);
        chk("signed5.y", y1, 12'h800);
        chk("signed5.ovf", o1, 1);

        a2 = 10'd1;
        step(1, 1, 2);
        chk("signed2.ovfhold", o1, 1);
        step(0, 1, 2);
        chk("signed2.y", y1, 12'hC00);
        chk("signed2.ovf", o1, 0);
        chk("wrap2.y", y2, 11'd2);
        chk("wrap2.ovf", o2, 0);

        // Multi-channel: channel 2 saturates alone.
        a3 = {8'd200, 8'd3, 8'd100};
        step(1, 1, 6);
        for (int i = 0; i < 5; i++) step(0, 1, 6);
        chk("ch3.valid", v3, 1);
        chk("ch3.y", y3, {10'd1023, 10'd18, 10'd600});
        chk("ch3.ovf", o3, 3'b100);

        step(1, 1, 4);
        step(0, 1, 4);
        rst = 1'b1;
        #1;
        chk("rst.y3", y3, 0);
        chk("rst.valid3", v3, 0);
        chk("rst.busy3", b3, 0);
        chk("rst.ovf3", o3, 0);
        chk("rst.y0", y0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 4);
            chk($sformatf("postrst%0d.valid", i), v3, 0);
            chk($sformatf("postrst%0d.busy", i), b3, 0);
        end
        step(1, 1, 2);
        chk("restart.novalid", v3, 0);
        step(0, 1, 2);
        chk("restart.valid", v3, 1);
        chk("restart.y", y3, {10'd400, 10'd6, 10'd200});
        chk("restart.ovf", o3, 3'b000);
        step(0, 0, 2);
        chk("restart.pulse", v3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
